// File: rtl/pe_pkg.sv
// Shared definitions for the vector processing element: op encoding, width helpers
// and statistics counter sizing.
package pe_pkg;

    typedef enum logic [1:0] {
        OP_MAC       = 2'd0,
        OP_LOAD_BIAS = 2'd1,
        OP_SHIFT     = 2'd2,
        OP_CLEAR     = 2'd3
    } op_e;

    localparam int SKIP_CNT_WIDTH = 16;

    // Returns at least 1 so a single-entry index still has a usable width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int prod_width(input int data_w, input int wgt_w);
        return data_w + wgt_w + 1;
    endfunction

    function automatic int sum_width(input int data_w, input int wgt_w, input int lanes);
        return prod_width(data_w, wgt_w) + clog2(lanes);
    endfunction

endpackage

// File: rtl/pe_lane_mult.sv
// One multiply lane: operand registers with zero-skip hold, lane mask and the
// sign-extended product of the registered operands.
module pe_lane_mult
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WIDTH_WGT  = 8,
    localparam int PROD_W    = prod_width(DATA_WIDTH, WIDTH_WGT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     act_sparsity_en,
    input  logic                     ia_sign,
    input  logic [DATA_WIDTH-1:0]    ia,
    input  logic [WIDTH_WGT-1:0]     wgt,
    output logic                     zero_skip,
    output logic                     masked,
    output logic signed [PROD_W-1:0] prod
);

    logic [DATA_WIDTH-1:0] ia_q;
    logic [WIDTH_WGT-1:0]  wgt_q;
    logic                  sign_q;
    logic                  mask_q;
    logic signed [PROD_W-1:0] ia_x;
    logic signed [PROD_W-1:0] wgt_x;

    assign zero_skip = in_valid && act_sparsity_en && (ia == '0);

    // Skipped lanes keep their old operands so the multiplier inputs stay quiet.
    always_ff @(posedge clk) begin
        if (reset) begin
            ia_q   <= '0;
            wgt_q  <= '0;
            sign_q <= 1'b0;
            mask_q <= 1'b0;
        end else if (in_valid) begin
            mask_q <= zero_skip;
            sign_q <= ia_sign;
            if (!zero_skip) begin
                ia_q  <= ia;
                wgt_q <= wgt;
            end
        end
    end

    assign ia_x   = {{WIDTH_WGT{sign_q & ia_q[DATA_WIDTH-1]}}, sign_q & ia_q[DATA_WIDTH-1], ia_q};
    assign wgt_x  = {{(DATA_WIDTH+1){wgt_q[WIDTH_WGT-1]}}, wgt_q};
    assign masked = mask_q;
    assign prod   = mask_q ? '0 : ia_x * wgt_x;

endmodule

// File: rtl/pe_vec.sv
// Vector PE: LANES multiplies reduced per beat into a multi-entry partial-sum bank,
// with zero-skip statistics, optional saturation and a registered ReLU read port.
module pe_vec
    import pe_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int WIDTH_WGT  = 8,
    parameter int PSUM_WIDTH = 32,
    parameter int BIAS_WIDTH = 16,
    parameter int PSUM_DEPTH = 4,
    parameter int SATURATE   = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic [1:0]                        op,
    input  logic [clog2(PSUM_DEPTH)-1:0]      wr_addr,
    input  logic [LANES*DATA_WIDTH-1:0]       ia,
    input  logic [LANES*WIDTH_WGT-1:0]        wgt,
    input  logic                              ia_sign,
    input  logic                              act_sparsity_en,
    input  logic [BIAS_WIDTH-1:0]             bias,
    input  logic [PSUM_WIDTH-1:0]             psum_in,
    input  logic                              rd_en,
    input  logic [clog2(PSUM_DEPTH)-1:0]      rd_addr,
    input  logic                              if_relu,
    output logic [PSUM_WIDTH-1:0]             psum_out,
    output logic                              out_valid,
    output logic                              ovf,
    output logic [SKIP_CNT_WIDTH-1:0]         skip_cnt,
    input  logic                              clr_stats
);

    localparam int AW     = clog2(PSUM_DEPTH);
    localparam int PROD_W = prod_width(DATA_WIDTH, WIDTH_WGT);
    localparam logic [PSUM_WIDTH-1:0] PSUM_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
    localparam logic [PSUM_WIDTH-1:0] PSUM_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};

    logic                  s1_valid_q;
    op_e                   op_q;
    logic [AW-1:0]         addr_q;
    logic [BIAS_WIDTH-1:0] bias_q;
    logic [PSUM_WIDTH-1:0] psum_in_q;

    logic [LANES-1:0]             lane_skip;
    logic [LANES-1:0]             lane_mask;
    logic [LANES-1:0][PROD_W-1:0] lane_prod;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        pe_lane_mult #(
            .DATA_WIDTH (DATA_WIDTH),
            .WIDTH_WGT  (WIDTH_WGT)
        ) u_lane (
            .clk             (clk),
            .reset           (reset),
            .in_valid        (in_valid),
            .act_sparsity_en (act_sparsity_en),
            .ia_sign         (ia_sign),
            .ia              (ia[g*DATA_WIDTH +: DATA_WIDTH]),
            .wgt             (wgt[g*WIDTH_WGT +: WIDTH_WGT]),
            .zero_skip       (lane_skip[g]),
            .masked          (lane_mask[g]),
            .prod            (lane_prod[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            op_q       <= OP_MAC;
            addr_q     <= '0;
            bias_q     <= '0;
            psum_in_q  <= '0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                op_q      <= op_e'(op);
                addr_q    <= wr_addr;
                bias_q    <= bias;
                psum_in_q <= psum_in;
            end
        end
    end

    logic [PSUM_WIDTH-1:0] lane_sum;
    logic [PSUM_WIDTH-1:0] bank_q [PSUM_DEPTH];
    logic [PSUM_WIDTH-1:0] cur;
    logic [PSUM_WIDTH:0]   acc_full;
    logic [PSUM_WIDTH-1:0] mac_res;
    logic                  mac_ovf;
    logic                  wr_en;
    logic [PSUM_WIDTH-1:0] wr_data;
    logic                  set_ovf;

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + {{(PSUM_WIDTH-PROD_W){lane_prod[i][PROD_W-1]}}, lane_prod[i]};
        end
    end

    // The bank value read here already includes the previous edge's write, so
    // back-to-back accumulation into one entry needs no forwarding or stall.
    always_comb begin
        cur      = (int'(addr_q) < PSUM_DEPTH) ? bank_q[addr_q] : '0;
        acc_full = {cur[PSUM_WIDTH-1], cur} + {lane_sum[PSUM_WIDTH-1], lane_sum};
        mac_ovf  = acc_full[PSUM_WIDTH] != acc_full[PSUM_WIDTH-1];
        mac_res  = acc_full[PSUM_WIDTH-1:0];
        if ((SATURATE != 0) && mac_ovf) begin
            mac_res = acc_full[PSUM_WIDTH] ? PSUM_MIN : PSUM_MAX;
        end
        wr_en   = s1_valid_q && (int'(addr_q) < PSUM_DEPTH);
        wr_data = '0;
        set_ovf = 1'b0;
        case (op_q)
            OP_MAC: begin
                wr_data = mac_res;
                if (&lane_mask) wr_en = 1'b0;
                set_ovf = wr_en && mac_ovf;
            end
            OP_LOAD_BIAS: wr_data = {{(PSUM_WIDTH-BIAS_WIDTH){bias_q[BIAS_WIDTH-1]}}, bias_q};
            OP_SHIFT:     wr_data = psum_in_q;
            OP_CLEAR:     wr_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PSUM_DEPTH; i++) bank_q[i] <= '0;
        end else if (wr_en) begin
            bank_q[addr_q] <= wr_data;
        end
    end

    logic                      ovf_q, ovf_d;
    logic [SKIP_CNT_WIDTH-1:0] skip_q, skip_d;
    logic [SKIP_CNT_WIDTH:0]   skip_sum;
    logic [PSUM_WIDTH-1:0]     psum_q, psum_d, rd_val;
    logic                      out_valid_q;

    // clr_stats wins over a same-cycle count or overflow event.
    always_comb begin
        skip_sum = {1'b0, skip_q} + (SKIP_CNT_WIDTH+1)'($countones(lane_skip));
        skip_d   = skip_sum[SKIP_CNT_WIDTH] ? '1 : skip_sum[SKIP_CNT_WIDTH-1:0];
        ovf_d    = ovf_q | set_ovf;
        if (clr_stats) begin
            skip_d = '0;
            ovf_d  = 1'b0;
        end
        rd_val = (int'(rd_addr) < PSUM_DEPTH) ? bank_q[rd_addr] : '0;
        if (if_relu && rd_val[PSUM_WIDTH-1]) rd_val = '0;
        psum_d = rd_en ? rd_val : psum_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q       <= 1'b0;
            skip_q      <= '0;
            psum_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ovf_q       <= ovf_d;
            skip_q      <= skip_d;
            psum_q      <= psum_d;
            out_valid_q <= rd_en;
        end
    end

    assign psum_out  = psum_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign skip_cnt  = skip_q;

endmodule

// File: tb/tb_pe_vec.sv
// Bench for pe_vec: a wrap-mode and a saturating instance share stimulus and are
// compared every cycle against a transaction-level model of the partial-sum bank.
module tb_pe_vec;
    import pe_pkg::*;

    localparam longint PMAX = (64'sd1 <<< 31) - 1;
    localparam longint PMIN = -(64'sd1 <<< 31);
    localparam longint SPAN = 64'sd1 <<< 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [1:0]  wr_addr = 2'd0;
    logic [31:0] ia = '0;
    logic [31:0] wgt = '0;
    logic        ia_sign = 1'b0;
    logic        act_sparsity_en = 1'b0;
    logic [15:0] bias = '0;
    logic [31:0] psum_in = '0;
    logic        rd_en = 1'b0;
    logic [1:0]  rd_addr = 2'd0;
    logic        if_relu = 1'b0;
    logic        clr_stats = 1'b0;

    logic [31:0] psum_out_w, psum_out_s;
    logic        out_valid_w, out_valid_s, ovf_w, ovf_s;
    logic [15:0] skip_cnt_w, skip_cnt_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_vec #(.SATURATE(0)) u_dut_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .wr_addr(wr_addr),
        .ia(ia), .wgt(wgt), .ia_sign(ia_sign), .act_sparsity_en(act_sparsity_en),
        .bias(bias), .psum_in(psum_in), .rd_en(rd_en), .rd_addr(rd_addr),
        .if_relu(if_relu), .psum_out(psum_out_w), .out_valid(out_valid_w),
        .ovf(ovf_w), .skip_cnt(skip_cnt_w), .clr_stats(clr_stats)
    );

    pe_vec #(.SATURATE(1)) u_dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .wr_addr(wr_addr),
        .ia(ia), .wgt(wgt), .ia_sign(ia_sign), .act_sparsity_en(act_sparsity_en),
        .bias(bias), .psum_in(psum_in), .rd_en(rd_en), .rd_addr(rd_addr),
        .if_relu(if_relu), .psum_out(psum_out_s), .out_valid(out_valid_s),
        .ovf(ovf_s), .skip_cnt(skip_cnt_s), .clr_stats(clr_stats)
    );

    // Model state: index 0 = wrap instance, 1 = saturating instance.
    longint      m_bank [2][4];
    logic        m_ovf [2];
    logic [31:0] m_out [2];
    logic        m_ov;
    int          m_skip;
    logic        p_valid;
    int          p_op, p_addr;
    longint      p_bias, p_psum, p_sum;

    function automatic longint beat_sum();
        longint s = 0;
        for (int l = 0; l < 4; l++) begin
            longint a = ia_sign ? longint'($signed(ia[l*8 +: 8])) : longint'(ia[l*8 +: 8]);
            longint w = longint'($signed(wgt[l*8 +: 8]));
            s += a * w;
        end
        return s;
    endfunction

    task automatic model_edge();
        int pop = 0;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int a = 0; a < 4; a++) m_bank[k][a] = 0;
                m_ovf[k] = 1'b0;
                m_out[k] = '0;
            end
            m_ov = 1'b0;
            m_skip = 0;
            p_valid = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (rd_en) begin
                    longint v = m_bank[k][rd_addr];
                    if (if_relu && v < 0) v = 0;
                    m_out[k] = 32'(v);
                end
            end
            m_ov = rd_en;
            if (p_valid) begin
                for (int k = 0; k < 2; k++) begin
                    case (p_op)
                        0: begin
                            longint r = m_bank[k][p_addr] + p_sum;
                            if (r > PMAX || r < PMIN) begin
                                m_ovf[k] = 1'b1;
                                if (k == 1) r = (r > 0) ? PMAX : PMIN;
                                else r = (r > 0) ? r - SPAN : r + SPAN;
                            end
                            m_bank[k][p_addr] = r;
                        end
                        1: m_bank[k][p_addr] = p_bias;
                        2: m_bank[k][p_addr] = p_psum;
                        default: m_bank[k][p_addr] = 0;
                    endcase
                end
            end
            if (in_valid && act_sparsity_en) begin
                for (int l = 0; l < 4; l++) if (ia[l*8 +: 8] == 8'd0) pop++;
            end
            if (clr_stats) begin
                m_ovf[0] = 1'b0;
                m_ovf[1] = 1'b0;
                m_skip = 0;
            end else begin
                m_skip = (m_skip + pop > 65535) ? 65535 : m_skip + pop;
            end
            p_valid = in_valid;
            if (in_valid) begin
                p_op   = int'(op);
                p_addr = int'(wr_addr);
                p_bias = longint'($signed(bias));
                p_psum = longint'($signed(psum_in));
                p_sum  = beat_sum();
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock: model update at the edge, output comparison 1 time unit later,
    // then single-cycle strobes drop.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("psum_out_wrap", psum_out_w, m_out[0]);
        chk("psum_out_sat", psum_out_s, m_out[1]);
        chk("out_valid_wrap", 32'(out_valid_w), 32'(m_ov));
        chk("out_valid_sat", 32'(out_valid_s), 32'(m_ov));
        chk("ovf_wrap", 32'(ovf_w), 32'(m_ovf[0]));
        chk("ovf_sat", 32'(ovf_s), 32'(m_ovf[1]));
        chk("skip_cnt", 32'(skip_cnt_w), 32'(m_skip));
        chk("skip_cnt_sat", 32'(skip_cnt_s), 32'(m_skip));
        in_valid = 1'b0;
        rd_en = 1'b0;
        clr_stats = 1'b0;
        reset = 1'b0;
    endtask

    task automatic issue(input logic [1:0] o, input logic [1:0] a, input logic [31:0] iav,
                         input logic [31:0] wv);
        in_valid = 1'b1;
        op = o;
        wr_addr = a;
        ia = iav;
        wgt = wv;
    endtask

    task automatic rd(input logic [1:0] a, input logic relu);
        rd_en = 1'b1;
        rd_addr = a;
        if_relu = relu;
    endtask

    initial begin
        // reset state
        reset = 1'b1;
        cycle();
        reset = 1'b1;
        cycle();
        chk("reset_out_valid", 32'(out_valid_w), 32'd0);
        chk("reset_skip", 32'(skip_cnt_s), 32'd0);

        // dot product with bias
        bias = 16'hFFFB;
        issue(OP_LOAD_BIAS, 2'd0, '0, '0);
        cycle();
        issue(OP_MAC, 2'd0, 32'h04030201, 32'h01010101);
        cycle();
        cycle();
        rd(2'd0, 1'b0);
        cycle();
        chk("dot_psum", psum_out_w, 32'd5);
        chk("dot_valid", 32'(out_valid_w), 32'd1);
        cycle();
        chk("dot_valid_drop", 32'(out_valid_w), 32'd0);
        chk("dot_psum_hold", psum_out_w, 32'd5);

        // signedness of activations
        issue(OP_CLEAR, 2'd3, '0, '0);
        cycle();
        ia_sign = 1'b1;
        issue(OP_MAC, 2'd3, 32'hFFFFFFFF, 32'h02020202);
        cycle();
        cycle();
        rd(2'd3, 1'b0);
        cycle();
        chk("signed_ia", psum_out_w, 32'hFFFFFFF8);
        issue(OP_CLEAR, 2'd3, '0, '0);
        cycle();
        ia_sign = 1'b0;
        issue(OP_MAC, 2'd3, 32'hFFFFFFFF, 32'h02020202);
        cycle();
        cycle();
        rd(2'd3, 1'b0);
        cycle();
        chk("unsigned_ia", psum_out_w, 32'd2040);

        // zero-skipping
        issue(OP_CLEAR, 2'd1, '0, '0);
        clr_stats = 1'b1;
        cycle();
        act_sparsity_en = 1'b1;
        for (int b = 0; b < 3; b++) begin
            issue(OP_MAC, 2'd1, 32'h00000300, 32'h01010101);
            cycle();
        end
        cycle();
        rd(2'd1, 1'b0);
        cycle();
        chk("sparse_psum", psum_out_w, 32'd9);
        chk("sparse_skip", 32'(skip_cnt_w), 32'd9);
        issue(OP_MAC, 2'd1, 32'h00000000, 32'h01010101);
        cycle();
        cycle();
        rd(2'd1, 1'b0);
        cycle();
        chk("allzero_psum", psum_out_w, 32'd9);
        chk("allzero_skip", 32'(skip_cnt_w), 32'd13);
        issue(OP_MAC, 2'd1, 32'h00000000, 32'h01010101);
        clr_stats = 1'b1;
        cycle();
        chk("clr_with_beat", 32'(skip_cnt_w), 32'd0);
        act_sparsity_en = 1'b0;

        // positive overflow: saturate vs wrap
        psum_in = 32'h7FFFFFF0;
        issue(OP_SHIFT, 2'd0, '0, '0);
        cycle();
        issue(OP_MAC, 2'd0, 32'h19191919, 32'h01010101);
        cycle();
        cycle();
        rd(2'd0, 1'b0);
        cycle();
        chk("sat_psum", psum_out_s, 32'h7FFFFFFF);
        chk("wrap_psum", psum_out_w, 32'h80000054);
        chk("sat_ovf", 32'(ovf_s), 32'd1);
        chk("wrap_ovf", 32'(ovf_w), 32'd1);
        clr_stats = 1'b1;
        cycle();
        chk("ovf_clear", 32'(ovf_s), 32'd0);

        // ReLU and read-before-write
        bias = 16'hFFF9;
        issue(OP_LOAD_BIAS, 2'd2, '0, '0);
        cycle();
        cycle();
        rd(2'd2, 1'b1);
        cycle();
        chk("relu_on", psum_out_w, 32'd0);
        rd(2'd2, 1'b0);
        cycle();
        chk("relu_off", psum_out_w, 32'hFFFFFFF9);
        issue(OP_MAC, 2'd2, 32'h00000001, 32'h01010101);
        cycle();
        rd(2'd2, 1'b0);
        cycle();
        chk("collide_old", psum_out_w, 32'hFFFFFFF9);
        rd(2'd2, 1'b0);
        cycle();
        chk("collide_new", psum_out_w, 32'hFFFFFFFA);

        // reset with an op in flight
        issue(OP_MAC, 2'd2, 32'h00000005, 32'h01010101);
        cycle();
        reset = 1'b1;
        issue(OP_MAC, 2'd2, 32'h00000005, 32'h01010101);
        cycle();
        chk("rst_mid_psum", psum_out_s, 32'd0);
        cycle();
        rd(2'd2, 1'b0);
        cycle();
        chk("rst_mid_bank", psum_out_s, 32'd0);

        // back-to-back accumulation into one entry
        issue(OP_CLEAR, 2'd0, '0, '0);
        cycle();
        for (int b = 0; b < 8; b++) begin
            ia_sign = 1'($urandom_range(0, 1));
            issue(OP_MAC, 2'd0, $urandom, $urandom);
            cycle();
        end
        cycle();
        rd(2'd0, 1'b0);
        cycle();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 7) begin
                int sel = $urandom_range(0, 9);
                logic [31:0] iav;
                for (int l = 0; l < 4; l++) iav[l*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
                ia_sign = 1'($urandom_range(0, 1));
                act_sparsity_en = 1'($urandom_range(0, 1));
                bias = 16'($urandom);
                psum_in = ($urandom_range(0, 1) != 0) ? (32'h7FFF0000 | 32'($urandom_range(0, 65535)))
                                                      : (32'h80000000 | 32'($urandom_range(0, 65535)));
                issue((sel < 6) ? OP_MAC : (sel == 6) ? OP_LOAD_BIAS : (sel == 7) ? OP_SHIFT : OP_CLEAR,
                      2'($urandom_range(0, 3)), iav, $urandom);
            end
            if ($urandom_range(0, 1) != 0) rd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 49) == 0) clr_stats = 1'b1;
            if ($urandom_range(0, 299) == 0) reset = 1'b1;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
